// File: rtl/fir_dec_pkg.sv
// Shared definitions for the FIR decimator output stage.
//   clog2 / acc_w : width helpers for the accumulator and counters
//   OUT_MAX/OUT_MIN: clamp limits for the default 12-bit output
//   sat_t/saturate: clamp a wide signed value to a signed width, flag clipping
package fir_dec_pkg;

  localparam int IN_W_D  = 20;
  localparam int OUT_W_D = 12;
  localparam int DEC_D   = 4;

  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r++;
      x = x >> 1;
    end
    return r;
  endfunction

  // Accumulator is wide enough that DEC full-scale samples never wrap.
  function automatic int acc_w(input int in_w, input int dec);
    return in_w + clog2(dec);
  endfunction

  function automatic logic signed [63:0] out_max(input int w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] out_min(input int w);
    return -(64'sd1 <<< (w - 1));
  endfunction

  localparam int                 ACC_W_D = acc_w(IN_W_D, DEC_D);
  localparam logic signed [63:0] OUT_MAX = out_max(OUT_W_D);
  localparam logic signed [63:0] OUT_MIN = out_min(OUT_W_D);

  typedef struct packed {
    logic               clip;
    logic signed [63:0] val;
  } sat_t;

  function automatic sat_t saturate(input logic signed [63:0] v, input int w);
    sat_t r;
    r.clip = 1'b0;
    r.val  = v;
    if (v > out_max(w)) begin
      r.clip = 1'b1;
      r.val  = out_max(w);
    end else if (v < out_min(w)) begin
      r.clip = 1'b1;
      r.val  = out_min(w);
    end
    return r;
  endfunction

endpackage

// File: rtl/fir_dec_fifo.sv
// Synchronous FIFO with a registered head word.
//   push/wdata : write (caller only pushes when not full, or full with pop)
//   pop        : read-advance (caller only pops when not empty)
//   rdata      : registered head, stable while no pop
//   full/empty/level : occupancy
// Same-cycle push+pop on a full FIFO keeps the level at DEPTH.
module fir_dec_fifo
  import fir_dec_pkg::*;
#(
  parameter int W     = 12,
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push,
  input  logic [W-1:0]            wdata,
  input  logic                    pop,
  output logic [W-1:0]            rdata,
  output logic                    full,
  output logic                    empty,
  output logic [clog2(DEPTH):0]   level
);

  localparam int AW = clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [DEPTH-1:0][W-1:0] mem;
  logic [AW-1:0]           wr_ptr, rd_ptr, rd_nxt;
  logic [LW-1:0]           cnt;
  logic [W-1:0]            head;

  assign rd_nxt = rd_ptr + AW'(1);
  assign full   = (cnt == LW'(DEPTH));
  assign empty  = (cnt == '0);
  assign level  = cnt;
  assign rdata  = head;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      head   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_nxt;
      cnt <= cnt + LW'(push) - LW'(pop);
      // Head tracks the entry that will be at rd_ptr after this edge.
      // With >1 entries the next word is already in mem; with exactly one
      // entry it can only come from a simultaneous push.
      if (pop) begin
        if (cnt > LW'(1))  head <= mem[rd_nxt];
        else if (push)     head <= wdata;
      end else if (empty && push) begin
        head <= wdata;
      end
    end
  end

endmodule

// File: rtl/fir_decim_out.sv
// Boxcar decimator (accumulate-and-dump by DEC) feeding a small output FIFO.
// Dump sum is shifted right by SHIFT, saturated to OUT_W, then pushed.
//   clk, rst_n        : clock, async active-low reset
//   in_valid, in_data : free-running signed FIR samples (no backpressure)
//   out_valid/out_ready/out_data : FIFO head handshake
//   fifo_level        : entries held
//   sat_pulse         : one cycle after a clipped result was pushed
//   ovf_sticky/ovf_clr: result dropped on full FIFO / synchronous clear
// Build option: FIR_DEC_ROUND_EN selects round-half-up instead of floor.
module fir_decim_out
  import fir_dec_pkg::*;
#(
  parameter int IN_W  = 20,
  parameter int OUT_W = 12,
  parameter int DEC   = 4,
  parameter int SHIFT = 2,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  input  logic [IN_W-1:0]        in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [OUT_W-1:0]       out_data,
  output logic [clog2(DEPTH):0]  fifo_level,
  output logic                   sat_pulse,
  output logic                   ovf_sticky,
  input  logic                   ovf_clr
);

  localparam int ACC_W = acc_w(IN_W, DEC);
  localparam int PH_W  = clog2(DEC);

`ifdef FIR_DEC_ROUND_EN
  localparam logic signed [63:0] RND = (SHIFT > 0) ? (64'sd1 <<< ((SHIFT > 0) ? SHIFT - 1 : 0)) : 64'sd0;
`else
  localparam logic signed [63:0] RND = 64'sd0;
`endif

  logic signed [ACC_W-1:0] acc, in_sx, sum;
  logic [PH_W-1:0]         phase;
  logic                    dump, pop, push_ok, drop;
  logic                    full, empty;
  logic signed [63:0]      sum64, scaled;
  sat_t                    sr;
  logic                    unused_hi;

  assign in_sx = {{(ACC_W-IN_W){in_data[IN_W-1]}}, in_data};
  assign sum   = acc + in_sx;
  assign dump  = in_valid && (phase == PH_W'(DEC - 1));

  // 64-bit working width: the rounding add can never wrap.
  assign sum64  = {{(64-ACC_W){sum[ACC_W-1]}}, sum};
  assign scaled = (sum64 + RND) >>> SHIFT;
  assign sr     = saturate(scaled, OUT_W);
  assign unused_hi = ^sr.val[63:OUT_W];

  assign out_valid = !empty;
  assign pop       = out_valid && out_ready;
  // A full FIFO still accepts the dump if the head leaves on the same edge.
  assign push_ok   = dump && (!full || pop);
  assign drop      = dump && full && !pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc   <= '0;
      phase <= '0;
    end else if (in_valid) begin
      if (dump) begin
        acc   <= '0;
        phase <= '0;
      end else begin
        acc   <= sum;
        phase <= phase + PH_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_pulse  <= 1'b0;
      ovf_sticky <= 1'b0;
    end else begin
      sat_pulse <= push_ok && sr.clip;
      if (drop)         ovf_sticky <= 1'b1;
      else if (ovf_clr) ovf_sticky <= 1'b0;
    end
  end

  fir_dec_fifo #(.W(OUT_W), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_ok),
    .wdata (sr.val[OUT_W-1:0]),
    .pop   (pop),
    .rdata (out_data),
    .full  (full),
    .empty (empty),
    .level (fifo_level)
  );

endmodule
